// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM state encoding,
// word geometry and the width of the frame's word-count field.
package loader_pkg;

    typedef enum logic [2:0] {
        LEN0,
        LEN1,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 16;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake from the host link plus the instruction memory
// write port; master is the loader, slave is the link/memory side.
interface program_loader_if #(
    parameter int ADDR_W = 8
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Collects little-endian bytes into a 32-bit word. word_out and full look ahead
// to include the byte being shifted this cycle, so the caller can register it.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        full
);

    logic [23:0] held;
    logic [1:0]  lane;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            held <= '0;
            lane <= '0;
        end else if (shift_en) begin
            case (lane)
                2'd0:    held[7:0]   <= byte_in;
                2'd1:    held[15:8]  <= byte_in;
                2'd2:    held[23:16] <= byte_in;
                default: ;
            endcase
            lane <= lane + 2'd1;
        end
    end

    // The top lane is never stored: the word is complete as soon as it arrives.
    always_comb begin
        word_out = {8'h00, held};
        if (shift_en) begin
            case (lane)
                2'd0:    word_out[7:0]   = byte_in;
                2'd1:    word_out[15:8]  = byte_in;
                2'd2:    word_out[23:16] = byte_in;
                default: word_out[31:24] = byte_in;
            endcase
        end
    end

    assign full = shift_en && (lane == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Receives a length/words/checksum frame over a byte link, writes the words
// into instruction memory and releases the processor once the frame checks out.
module program_loader
    import loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    program_loader_if.master   bus,
    input  logic               load_req,
    output logic               cpu_rst,
    output logic               start,
    output logic               done,
    output logic               error
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] word_idx;
    logic [CNT_W-1:0] next_idx;
    logic [CNT_W-1:0] req_count;
    logic [7:0]       csum;
    logic             xfer;
    logic [31:0]      asm_word;
    logic             asm_full;

    assign xfer      = bus.byte_valid && bus.byte_ready;
    assign next_idx  = word_idx + CNT_W'(1);
    assign req_count = {bus.byte_data, count[7:0]};

    byte_assembler u_assembler (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == LEN0),
        .shift_en (xfer && (state == DATA)),
        .byte_in  (bus.byte_data),
        .word_out (asm_word),
        .full     (asm_full)
    );

    // byte_ready is registered, so every transition sets it for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= LEN0;
            count          <= '0;
            word_idx       <= '0;
            csum           <= '0;
            bus.byte_ready <= 1'b0;
            bus.im_we      <= 1'b0;
            bus.im_addr    <= '0;
            bus.im_wdata   <= '0;
            cpu_rst        <= 1'b1;
            start          <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.im_we <= 1'b0;
            start     <= 1'b0;
            case (state)
                LEN0: begin
                    bus.byte_ready <= 1'b1;
                    if (xfer) begin
                        count[7:0] <= bus.byte_data;
                        csum       <= csum ^ bus.byte_data;
                        state      <= LEN1;
                    end
                end
                LEN1: begin
                    if (xfer) begin
                        count[CNT_W-1:8] <= bus.byte_data;
                        csum             <= csum ^ bus.byte_data;
                        if (req_count > CNT_W'(DEPTH)) begin
                            state          <= ERR;
                            bus.byte_ready <= 1'b0;
                            error          <= 1'b1;
                        end else if (req_count == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ bus.byte_data;
                        if (asm_full) begin
                            state          <= WRITE;
                            bus.byte_ready <= 1'b0;
                            bus.im_we      <= 1'b1;
                            bus.im_addr    <= ADDR_W'(word_idx << 2);
                            bus.im_wdata   <= asm_word;
                        end
                    end
                end
                WRITE: begin
                    word_idx       <= next_idx;
                    bus.byte_ready <= 1'b1;
                    state          <= (next_idx == count) ? CSUM : DATA;
                end
                CSUM: begin
                    if (xfer) begin
                        bus.byte_ready <= 1'b0;
                        if (bus.byte_data == csum) begin
                            state   <= DONE;
                            cpu_rst <= 1'b0;
                            done    <= 1'b1;
                            start   <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (load_req) begin
                        state          <= LEN0;
                        bus.byte_ready <= 1'b1;
                        cpu_rst        <= 1'b1;
                        done           <= 1'b0;
                        error          <= 1'b0;
                        csum           <= '0;
                        word_idx       <= '0;
                    end
                end
                default: state <= LEN0;
            endcase
        end
    end

endmodule
